rv_core_mc: RTL and testbench
=============================

Name: rv_core_mc

Overview:
- Parametrised RV32I/RV32E integer core, the next generation of the SoC execute engine.
- Decoupled from RAMIO through two generic request/valid memory ports that tolerate any memory latency, so cache misses and burst refills stall the core cleanly.
- Performs byte-lane alignment and load extension internally.
- Traps on illegal or misaligned accesses instead of silently executing them.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- REG_COUNT, 32, architectural registers; 32 = RV32I, 16 = RV32E. Other values are rejected at elaboration.
- ADDR_WIDTH, 32, width of imem_addr and dmem_addr; upper bits of computed addresses are dropped.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_WIDTH  fetch address, word aligned
- imem_rdata  in  32  fetched instruction
- imem_valid  in  1  imem_rdata valid; completes the fetch
- dmem_re  out  1  data read request
- dmem_we  out  1  data write request
- dmem_addr  out  ADDR_WIDTH  word-aligned data address
- dmem_wdata  out  32  lane-shifted store data
- dmem_wstrb  out  4  byte write strobes
- dmem_rdata  in  32  full word read
- dmem_valid  in  1  completes a data read or write
- mem_ready  in  1  memory initialised; both ports usable
- initiated  out  1  core has left INIT
- is_stalled  out  1  core is waiting on imem_valid or dmem_valid
- trap  out  1  sticky; core halted
- trap_cause  out  2  01 illegal instruction, 10 misaligned load/store, 11 misaligned jump/branch target

Behaviour:
- Reset state:
  - All outputs are 0 except imem_addr = RESET_VECTOR.
  - pc = RESET_VECTOR; state = INIT.
  - The register file is not reset; x0 always reads 0.
- State INIT: waits for mem_ready = 1, then sets initiated = 1 and goes to FETCH.
- State FETCH:
  - imem_req = 1 and imem_addr = pc, both held stable until imem_valid.
  - On imem_valid, ir <= imem_rdata and the core goes to EXEC.
  - is_stalled = 1 while waiting.
- State EXEC: one cycle.
  - ALU, LUI, AUIPC, JAL, JALR and branches complete here: rd is written, pc is updated, and the core goes to FETCH.
  - Load/store: compute ea = rs1 + imm. If the access is aligned, go to MEM; otherwise enter TRAP with cause 10.
    - Alignment rule: half-word needs ea[0] = 0; word needs ea[1:0] = 0.
  - Jump or taken branch whose target[1:0] != 0: enter TRAP with cause 11; rd is not written.
  - Illegal instruction (unknown opcode/funct, or register index >= REG_COUNT): enter TRAP with cause 01.
- State MEM:
  - dmem_re or dmem_we is held with a stable address, wdata and wstrb until dmem_valid.
  - Store strobes: SB = 0001 << ea[1:0]; SH = 0011 << ea[1:0]; SW = 1111. wdata is rs2 replicated into the lanes.
  - Loads on dmem_valid: select the byte/half at ea[1:0]; sign- or zero-extend per funct3; write rd.
  - After dmem_valid: pc <= pc + 4 and the core goes to FETCH.
- State TRAP:
  - trap = 1; all requests are deasserted and the core stays here until rst.
  - pc holds the address of the faulting instruction.
- Writes to x0 are discarded. Shift amounts use [4:0]. Arithmetic wraps modulo 2^32.
- dmem_valid or imem_valid outside the matching wait state is ignored.
- rst asserted mid-transaction: returns to INIT on the next edge and drops requests the same cycle. The memory side must tolerate abandoned requests.
- The core never issues imem and dmem requests in the same cycle.

Optional Feature:
- Macro: RV_CORE_COUNTERS_EN.
- When defined:
  - Adds 64-bit cycle and instret counters, reset to 0.
  - cycle increments every cycle after initiated.
  - instret increments per retired instruction; a trap does not retire.
  - CSRRS with rs1 = x0 reads them: cycle is C00/C80, instret is C02/C82.
  - Any other SYSTEM encoding raises trap cause 01.
- When undefined: all SYSTEM opcodes raise trap cause 01.

Test Plan:
- mem_ready held 0 for 10 cycles, then 1 -> initiated rises 1 cycle later; first imem_addr = RESET_VECTOR.
- ADDI x1,x0,-5; SW x1,0(x0); LB x2,3(x0); LBU x3,3(x0); dmem_valid delayed 3 cycles -> x2 = 0xFFFFFFFF, x3 = 0xFF, is_stalled high during each wait.
- SB to address 0x102 with rs2 = 0x12345678 -> dmem_addr = 0x100, wstrb = 0100, wdata[23:16] = 0x78.
- LW from 0x101 -> trap = 1, trap_cause = 10, no dmem request issued, pc = address of the LW.
- REG_COUNT = 16, ADD x20,x1,x2 -> trap_cause = 01.
- BNE taken to +8 with imem_valid latency of 5 cycles -> next imem_addr = pc + 8. With RV_CORE_COUNTERS_EN, rdinstret afterwards = number of retired instructions.

Source files
------------

// File: rtl/rv_core_mc.sv
// rv_core_mc: multi-cycle RV32I/RV32E integer core with decoupled fetch and data ports.
// Sequence: INIT -> FETCH -> EXEC -> (MEM) -> FETCH. Faults park the core in TRAP until rst.
// Optional macro RV_CORE_COUNTERS_EN adds 64-bit cycle/instret counters readable via CSRRS.
// Handshake: a request (imem_req, dmem_re, dmem_we) and its address/data stay stable until the
// matching valid is sampled high on a clock edge; valids arriving in any other state are ignored.
module rv_core_mc #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          REG_COUNT    = 32,
   parameter int          ADDR_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_rdata,
   input  logic                  imem_valid,
   output logic                  dmem_re,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [31:0]           dmem_wdata,
   output logic [3:0]            dmem_wstrb,
   input  logic [31:0]           dmem_rdata,
   input  logic                  dmem_valid,
   input  logic                  mem_ready,
   output logic                  initiated,
   output logic                  is_stalled,
   output logic                  trap,
   output logic [1:0]            trap_cause
);
   if (REG_COUNT != 32 && REG_COUNT != 16) begin : g_bad_reg_count
      $error("rv_core_mc: REG_COUNT must be 16 or 32");
   end
   if (ADDR_WIDTH < 3 || ADDR_WIDTH > 32) begin : g_bad_addr_width
      $error("rv_core_mc: ADDR_WIDTH must be in 3..32");
   end

   localparam int         RIW = (REG_COUNT == 16) ? 4 : 5;
   localparam logic [5:0] RC6 = 6'(REG_COUNT);

   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {S_INIT, S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

   state_t                state_q;
   logic [31:0]           pc_q, ir_q;
   logic                  initiated_q, trap_q, dmem_re_q, dmem_we_q;
   logic [1:0]            cause_q, ea_lo_q;
   logic [ADDR_WIDTH-1:0] dmem_addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic [31:0]           rf_q [REG_COUNT];

   // Instruction fields
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd_idx, rs1_idx, rs2_idx;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
   assign opcode  = ir_q[6:0];
   assign rd_idx  = ir_q[11:7];
   assign funct3  = ir_q[14:12];
   assign rs1_idx = ir_q[19:15];
   assign rs2_idx = ir_q[24:20];
   assign funct7  = ir_q[31:25];
   assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u   = {ir_q[31:12], 12'd0};
   assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : rf_q[rs1_idx[RIW-1:0]];
   assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : rf_q[rs2_idx[RIW-1:0]];

   function automatic logic [31:0] alu_op(input logic [2:0] op, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b000:  alu_op = alt ? (a - b) : (a + b);
         3'b001:  alu_op = a << b[4:0];
         3'b010:  alu_op = {31'd0, $signed(a) < $signed(b)};
         3'b011:  alu_op = {31'd0, a < b};
         3'b100:  alu_op = a ^ b;
         3'b101:  alu_op = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'b110:  alu_op = a | b;
         default: alu_op = a & b;
      endcase
   endfunction

`ifdef RV_CORE_COUNTERS_EN
   logic [63:0] cycle_q, instret_q;
`endif

   logic        ex_illegal, ex_wr, ex_jump, ex_mem, ex_store, ex_mis, taken;
   logic        uses_rd, uses_rs1, uses_rs2;
   logic [31:0] ex_wdata, ex_next_pc, ea, st_wdata;
   logic [3:0]  st_strb;
   logic [1:0]  ex_cause;

   // EXEC decode: result value, next pc, memory request and trap cause of the instruction in ir_q
   always_comb begin
      ex_illegal = 1'b0; ex_wr = 1'b0; ex_jump = 1'b0; ex_mem = 1'b0; ex_store = 1'b0;
      uses_rd = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0; taken = 1'b0;
      ex_wdata = 32'd0; ex_next_pc = pc_q + 32'd4; ex_cause = 2'b00;
      ea = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
      ex_mis = (funct3[1:0] == 2'b01 && ea[0]) || (funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
      case (funct3[1:0])
         2'b00:   begin st_wdata = {4{rs2_val[7:0]}};  st_strb = 4'b0001 << ea[1:0]; end
         2'b01:   begin st_wdata = {2{rs2_val[15:0]}}; st_strb = 4'b0011 << ea[1:0]; end
         default: begin st_wdata = rs2_val;            st_strb = 4'b1111;           end
      endcase
      case (opcode)
         OP_LUI:   begin uses_rd = 1'b1; ex_wr = 1'b1; ex_wdata = imm_u; end
         OP_AUIPC: begin uses_rd = 1'b1; ex_wr = 1'b1; ex_wdata = pc_q + imm_u; end
         OP_JAL: begin
            uses_rd = 1'b1; ex_wr = 1'b1; ex_wdata = pc_q + 32'd4;
            ex_jump = 1'b1; ex_next_pc = pc_q + imm_j;
         end
         OP_JALR: begin
            uses_rd = 1'b1; uses_rs1 = 1'b1; ex_wr = 1'b1; ex_wdata = pc_q + 32'd4;
            ex_jump = 1'b1; ex_next_pc = (rs1_val + imm_i) & ~32'd1;
            ex_illegal = (funct3 != 3'b000);
         end
         OP_BRANCH: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            case (funct3)
               3'b000:  taken = (rs1_val == rs2_val);
               3'b001:  taken = (rs1_val != rs2_val);
               3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
               3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
               3'b110:  taken = (rs1_val < rs2_val);
               3'b111:  taken = (rs1_val >= rs2_val);
               default: ex_illegal = 1'b1;
            endcase
            ex_jump = taken;
            if (taken) ex_next_pc = pc_q + imm_b;
         end
         OP_LOAD: begin
            uses_rd = 1'b1; uses_rs1 = 1'b1; ex_mem = 1'b1;
            ex_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OP_STORE: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; ex_mem = 1'b1; ex_store = 1'b1;
            ex_illegal = (funct3[2] || funct3[1:0] == 2'b11);
         end
         OP_IMM: begin
            uses_rd = 1'b1; uses_rs1 = 1'b1; ex_wr = 1'b1;
            ex_wdata = alu_op(funct3, (funct3 == 3'b101) & ir_q[30], rs1_val, imm_i);
            ex_illegal = (funct3 == 3'b001 && funct7 != 7'd0) ||
                         (funct3 == 3'b101 && funct7 != 7'd0 && funct7 != 7'b0100000);
         end
         OP_REG: begin
            uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; ex_wr = 1'b1;
            ex_wdata = alu_op(funct3, ir_q[30], rs1_val, rs2_val);
            ex_illegal = !(funct7 == 7'd0 ||
                           (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OP_SYSTEM: begin
`ifdef RV_CORE_COUNTERS_EN
            uses_rd = 1'b1; ex_wr = 1'b1;
            case (ir_q[31:20])
               12'hC00: ex_wdata = cycle_q[31:0];
               12'hC80: ex_wdata = cycle_q[63:32];
               12'hC02: ex_wdata = instret_q[31:0];
               12'hC82: ex_wdata = instret_q[63:32];
               default: ex_illegal = 1'b1;
            endcase
            if (funct3 != 3'b010 || rs1_idx != 5'd0) ex_illegal = 1'b1;
`else
            ex_illegal = 1'b1;
`endif
         end
         default: ex_illegal = 1'b1;
      endcase
      if ((uses_rd && {1'b0, rd_idx} >= RC6) || (uses_rs1 && {1'b0, rs1_idx} >= RC6) ||
          (uses_rs2 && {1'b0, rs2_idx} >= RC6)) ex_illegal = 1'b1;
      if (ex_illegal)                                    ex_cause = 2'b01;
      else if (ex_mem && ex_mis)                         ex_cause = 2'b10;
      else if (ex_jump && ex_next_pc[1:0] != 2'b00)      ex_cause = 2'b11;
   end

   // Load lane select and sign/zero extension of the returned word
   logic [31:0] ld_shift, ld_val;
   assign ld_shift = dmem_rdata >> {ea_lo_q, 3'b000};
   always_comb begin
      case (funct3)
         3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_val = {24'd0, ld_shift[7:0]};
         3'b101:  ld_val = {16'd0, ld_shift[15:0]};
         default: ld_val = ld_shift;
      endcase
   end

   logic rf_we;
   assign rf_we = !rst && (rd_idx != 5'd0) &&
                  ((state_q == S_EXEC && ex_cause == 2'b00 && ex_wr) ||
                   (state_q == S_MEM && dmem_valid && !dmem_we_q));

   // Register file write port (not reset; x0 is never written)
   always_ff @(posedge clk) begin
      if (rf_we) rf_q[rd_idx[RIW-1:0]] <= (state_q == S_MEM) ? ld_val : ex_wdata;
   end

   // Main control FSM with registered request and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT; pc_q <= RESET_VECTOR; ir_q <= 32'd0;
         initiated_q <= 1'b0; trap_q <= 1'b0; cause_q <= 2'b00;
         dmem_re_q <= 1'b0; dmem_we_q <= 1'b0; dmem_addr_q <= '0;
         wdata_q <= 32'd0; wstrb_q <= 4'd0; ea_lo_q <= 2'b00;
      end else begin
         case (state_q)
            S_INIT: if (mem_ready) begin
               initiated_q <= 1'b1; state_q <= S_FETCH;
            end
            S_FETCH: if (imem_valid) begin
               ir_q <= imem_rdata; state_q <= S_EXEC;
            end
            S_EXEC: begin
               if (ex_cause != 2'b00) begin
                  trap_q <= 1'b1; cause_q <= ex_cause; state_q <= S_TRAP;
               end else if (ex_mem) begin
                  dmem_re_q <= !ex_store; dmem_we_q <= ex_store;
                  dmem_addr_q <= {ea[ADDR_WIDTH-1:2], 2'b00};
                  wdata_q <= st_wdata; wstrb_q <= ex_store ? st_strb : 4'd0;
                  ea_lo_q <= ea[1:0]; state_q <= S_MEM;
               end else begin
                  pc_q <= ex_next_pc; state_q <= S_FETCH;
               end
            end
            S_MEM: if (dmem_valid) begin
               dmem_re_q <= 1'b0; dmem_we_q <= 1'b0;
               pc_q <= pc_q + 32'd4; state_q <= S_FETCH;
            end
            S_TRAP:  state_q <= S_TRAP;
            default: state_q <= S_INIT;
         endcase
      end
   end

`ifdef RV_CORE_COUNTERS_EN
   logic retire;
   assign retire = (state_q == S_EXEC && ex_cause == 2'b00 && !ex_mem) ||
                   (state_q == S_MEM && dmem_valid);
   // Free-running cycle counter and retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= 64'd0; instret_q <= 64'd0;
      end else begin
         if (initiated_q) cycle_q <= cycle_q + 64'd1;
         if (retire) instret_q <= instret_q + 64'd1;
      end
   end
`endif

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q[ADDR_WIDTH-1:0];
   assign dmem_re    = dmem_re_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_wstrb = wstrb_q;
   assign initiated  = initiated_q;
   assign is_stalled = (state_q == S_FETCH) || (state_q == S_MEM);
   assign trap       = trap_q;
   assign trap_cause = cause_q;
endmodule

// File: tb/tb_rv_core_mc.sv
// Directed bench for rv_core_mc: an RV32I instance runs a hand-assembled program with
// hand-computed results observed through stores; an RV32E instance checks register range traps.
module tb_rv_core_mc;
   localparam logic [31:0] RV = 32'h0000_0080;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, e_rst;

   logic        imem_req, imem_valid, dmem_re, dmem_we, dmem_valid, mem_ready;
   logic        initiated, is_stalled, trap;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic [1:0]  trap_cause;

   logic        e_imem_req, e_imem_valid, e_dmem_re, e_dmem_we, e_dmem_valid, e_mem_ready;
   logic        e_initiated, e_is_stalled, e_trap;
   logic [31:0] e_imem_addr, e_imem_rdata, e_dmem_addr, e_dmem_wdata, e_dmem_rdata;
   logic [3:0]  e_dmem_wstrb;
   logic [1:0]  e_trap_cause;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_trap_pc;

   rv_core_mc #(.RESET_VECTOR(RV), .REG_COUNT(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .dmem_re(dmem_re), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid), .mem_ready(mem_ready),
      .initiated(initiated), .is_stalled(is_stalled), .trap(trap), .trap_cause(trap_cause));

   rv_core_mc #(.RESET_VECTOR(RV), .REG_COUNT(16), .ADDR_WIDTH(32)) dut_e (
      .clk(clk), .rst(e_rst), .imem_req(e_imem_req), .imem_addr(e_imem_addr),
      .imem_rdata(e_imem_rdata), .imem_valid(e_imem_valid), .dmem_re(e_dmem_re),
      .dmem_we(e_dmem_we), .dmem_addr(e_dmem_addr), .dmem_wdata(e_dmem_wdata),
      .dmem_wstrb(e_dmem_wstrb), .dmem_rdata(e_dmem_rdata), .dmem_valid(e_dmem_valid),
      .mem_ready(e_mem_ready), .initiated(e_initiated), .is_stalled(e_is_stalled),
      .trap(e_trap), .trap_cause(e_trap_cause));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // driver: serve one instruction fetch after lat wait cycles
   task automatic fetch(input string tag, input logic [31:0] exp_pc, input logic [31:0] instr,
                        input int lat);
      int n = 0;
      while (imem_req !== 1'b1 && n < 40) begin step(1); n++; end
      chk({tag, ":imem_req"}, 32'(imem_req), 32'd1);
      chk({tag, ":imem_addr"}, imem_addr, exp_pc);
      step(lat);
      chk({tag, ":stall_f"}, 32'(is_stalled), 32'd1);
      chk({tag, ":addr_hold"}, imem_addr, exp_pc);
      imem_rdata = instr; imem_valid = 1'b1;
      step(1);
      imem_valid = 1'b0; imem_rdata = 32'd0;
      chk({tag, ":exec_nostall"}, {31'd0, is_stalled | imem_req}, 32'd0);
   endtask

   // driver: serve one data access, checking the request fields first
   task automatic dmem(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                       input logic [31:0] rdata, input int lat);
      int n = 0;
      while ((dmem_re | dmem_we) !== 1'b1 && n < 40) begin step(1); n++; end
      chk({tag, ":we"}, 32'(dmem_we), 32'(exp_we));
      chk({tag, ":re"}, 32'(dmem_re), 32'(!exp_we));
      chk({tag, ":daddr"}, dmem_addr, exp_addr);
      chk({tag, ":no_imem"}, 32'(imem_req), 32'd0);
      if (exp_we) begin
         chk({tag, ":wdata"}, dmem_wdata, exp_wdata);
         chk({tag, ":wstrb"}, 32'(dmem_wstrb), 32'(exp_wstrb));
      end
      step(lat);
      chk({tag, ":stall_m"}, 32'(is_stalled), 32'd1);
      dmem_rdata = rdata; dmem_valid = 1'b1;
      step(1);
      dmem_valid = 1'b0; dmem_rdata = 32'd0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; mem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0;
      dmem_valid = 1'b0; dmem_rdata = 32'd0;
      e_rst = 1'b1; e_mem_ready = 1'b0; e_imem_valid = 1'b0; e_imem_rdata = 32'd0;
      e_dmem_valid = 1'b0; e_dmem_rdata = 32'd0;
      step(3);
      chk("rst:imem_req", 32'(imem_req), 32'd0);
      chk("rst:imem_addr", imem_addr, RV);
      chk("rst:dmem_req", {30'd0, dmem_re, dmem_we}, 32'd0);
      chk("rst:initiated", 32'(initiated), 32'd0);
      chk("rst:stall", 32'(is_stalled), 32'd0);
      chk("rst:trap", {29'd0, trap, trap_cause}, 32'd0);
      chk("rst:wstrb", 32'(dmem_wstrb), 32'd0);
      rst = 1'b0;
      step(10);
      chk("init_wait:initiated", 32'(initiated), 32'd0);
      chk("init_wait:imem_req", 32'(imem_req), 32'd0);
      mem_ready = 1'b1;
      step(1);
      chk("init_done:initiated", 32'(initiated), 32'd1);

      fetch("addi_x1", RV + 32'h00, 32'hFFB00093, 0);
      fetch("sw_x1", RV + 32'h04, 32'h00102023, 1);
      dmem("sw_x1", 1'b1, 32'h0, 32'hFFFFFFFB, 4'hF, 32'd0, 3);
      fetch("lb_x2", RV + 32'h08, 32'h00300103, 0);
      dmem("lb_x2", 1'b0, 32'h0, 32'd0, 4'h0, 32'hFFFFFFFB, 3);
      fetch("lbu_x3", RV + 32'h0C, 32'h00304183, 2);
      dmem("lbu_x3", 1'b0, 32'h0, 32'd0, 4'h0, 32'hFFFFFFFB, 3);
      fetch("sw_x2", RV + 32'h10, 32'h00202423, 0);
      dmem("sw_x2", 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 32'd0, 0);
      fetch("sw_x3", RV + 32'h14, 32'h00302623, 0);
      dmem("sw_x3", 1'b1, 32'hC, 32'h000000FF, 4'hF, 32'd0, 1);
      fetch("lh_x4", RV + 32'h18, 32'h00201203, 0);
      dmem("lh_x4", 1'b0, 32'h0, 32'd0, 4'h0, 32'h80011234, 2);
      fetch("sw_x4", RV + 32'h1C, 32'h00402823, 0);
      dmem("sw_x4", 1'b1, 32'h10, 32'hFFFF8001, 4'hF, 32'd0, 0);
      fetch("lui_x5", RV + 32'h20, 32'h123452B7, 0);
      fetch("addi_x5", RV + 32'h24, 32'h67828293, 0);
      fetch("sb_x5", RV + 32'h28, 32'h10500123, 0);
      dmem("sb_x5", 1'b1, 32'h100, 32'h78787878, 4'b0100, 32'd0, 2);
      fetch("sh_x5", RV + 32'h2C, 32'h00501123, 0);
      dmem("sh_x5", 1'b1, 32'h0, 32'h56785678, 4'b1100, 32'd0, 0);
      fetch("sub_x7", RV + 32'h30, 32'h401283B3, 0);
      fetch("srai_x8", RV + 32'h34, 32'h4010D413, 0);
      fetch("slt_x9", RV + 32'h38, 32'h0000A4B3, 0);
      fetch("sw_x7", RV + 32'h3C, 32'h00702C23, 0);
      dmem("sw_x7", 1'b1, 32'h18, 32'h1234567D, 4'hF, 32'd0, 0);
      fetch("sw_x8", RV + 32'h40, 32'h00802E23, 0);
      dmem("sw_x8", 1'b1, 32'h1C, 32'hFFFFFFFD, 4'hF, 32'd0, 0);
      fetch("sw_x9", RV + 32'h44, 32'h02902023, 0);
      dmem("sw_x9", 1'b1, 32'h20, 32'h00000001, 4'hF, 32'd0, 0);
      fetch("jal_x10", RV + 32'h48, 32'h0080056F, 0);
      fetch("sw_x10", RV + 32'h50, 32'h02A02223, 0);
      dmem("sw_x10", 1'b1, 32'h24, RV + 32'h4C, 4'hF, 32'd0, 0);
      fetch("bne", RV + 32'h54, 32'h00009463, 5);
`ifdef RV_CORE_COUNTERS_EN
      fetch("csrrs_instret", RV + 32'h5C, 32'hC0202373, 5);
      fetch("sw_x6", RV + 32'h60, 32'h02602423, 0);
      dmem("sw_x6", 1'b1, 32'h28, 32'd21, 4'hF, 32'd0, 0);
      fetch("ecall", RV + 32'h64, 32'h00000073, 0);
      exp_trap_pc = RV + 32'h64;
`else
      fetch("csrrs_nocnt", RV + 32'h5C, 32'hC0202373, 5);
      exp_trap_pc = RV + 32'h5C;
`endif
      step(1);
      chk("sys_trap:trap", 32'(trap), 32'd1);
      chk("sys_trap:cause", 32'(trap_cause), 32'd1);
      chk("sys_trap:pc", imem_addr, exp_trap_pc);
      step(4);
      chk("sys_trap:sticky", {29'd0, trap, trap_cause}, 32'd5);
      chk("sys_trap:no_req", {29'd0, imem_req, dmem_re, dmem_we}, 32'd0);

      rst = 1'b1; step(1);
      chk("rst2:clear", {28'd0, initiated, trap, trap_cause}, 32'd0);
      rst = 1'b0; step(1);
      fetch("addi_x11", RV, 32'h10100593, 0);
      fetch("lw_mis", RV + 32'h04, 32'h0005A603, 0);
      step(1);
      chk("lw_mis:trap", 32'(trap), 32'd1);
      chk("lw_mis:cause", 32'(trap_cause), 32'd2);
      chk("lw_mis:pc", imem_addr, RV + 32'h04);
      step(3);
      chk("lw_mis:no_dmem", {30'd0, dmem_re, dmem_we}, 32'd0);

      rst = 1'b1; step(1);
      rst = 1'b0; step(1);
      chk("midrst:fetching", 32'(imem_req), 32'd1);
      rst = 1'b1; step(1);
      chk("midrst:dropped", {30'd0, imem_req, is_stalled}, 32'd0);
      chk("midrst:initiated", 32'(initiated), 32'd0);
      rst = 1'b0;
      fetch("jal_mis", RV, 32'h0020006F, 2);
      step(1);
      chk("jal_mis:trap", 32'(trap), 32'd1);
      chk("jal_mis:cause", 32'(trap_cause), 32'd3);
      chk("jal_mis:pc", imem_addr, RV);

      // RV32E instance
      e_rst = 1'b0; e_mem_ready = 1'b1; step(1);
      chk("e:imem_req", 32'(e_imem_req), 32'd1);
      chk("e:imem_addr", e_imem_addr, RV);
      e_imem_rdata = 32'hFFB00093; e_imem_valid = 1'b1; step(1);
      e_imem_valid = 1'b0; step(1);
      chk("e:legal_no_trap", 32'(e_trap), 32'd0);
      chk("e:next_pc", e_imem_addr, RV + 32'h04);
      e_imem_rdata = 32'h00208A33; e_imem_valid = 1'b1; step(1);
      e_imem_valid = 1'b0; step(1);
      chk("e:add_x20_trap", 32'(e_trap), 32'd1);
      chk("e:add_x20_cause", 32'(e_trap_cause), 32'd1);
      chk("e:add_x20_pc", e_imem_addr, RV + 32'h04);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
